// File: rtl/oled_pkg.sv
// Shared types and defaults for the OLED init sequencer.
// Optional GDDRAM clear phase is built when OLED_SEQ_CLEAR_EN is defined.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_CMD_ISSUE,
    ST_CMD_WAIT,
    ST_CLR_ISSUE,
    ST_CLR_WAIT,
    ST_READY,
    ST_USR_ISSUE,
    ST_USR_WAIT
  } oled_state_e;

  localparam logic OLED_CMD  = 1'b0;
  localparam logic OLED_DATA = 1'b1;

  localparam int DEF_INIT_LEN     = 31;
  localparam int DEF_CLR_BYTES    = 1024;
  localparam int DEF_PWRUP_CYCLES = 12000;

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 init command table, combinational idx -> command byte.
// Out-of-range indices return the controller NOP (E3).
module oled_init_rom
  import oled_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       cmd
);

  always_comb begin
    cmd = 8'hE3;
    case (int'(idx))
      0:  cmd = 8'hAE;
      1:  cmd = 8'hD5;
      2:  cmd = 8'h80;
      3:  cmd = 8'hA8;
      4:  cmd = 8'h3F;
      5:  cmd = 8'hD3;
      6:  cmd = 8'h00;
      7:  cmd = 8'h40;
      8:  cmd = 8'h8D;
      9:  cmd = 8'h14;
      10: cmd = 8'h20;
      11: cmd = 8'h00;
      12: cmd = 8'hA1;
      13: cmd = 8'hC8;
      14: cmd = 8'hDA;
      15: cmd = 8'h12;
      16: cmd = 8'h81;
      17: cmd = 8'hCF;
      18: cmd = 8'hD9;
      19: cmd = 8'hF1;
      20: cmd = 8'hDB;
      21: cmd = 8'h40;
      22: cmd = 8'hA4;
      23: cmd = 8'hA6;
      24: cmd = 8'h21;
      25: cmd = 8'h00;
      26: cmd = 8'h7F;
      27: cmd = 8'h22;
      28: cmd = 8'h00;
      29: cmd = 8'h07;
      30: cmd = 8'hAF;
      default: cmd = 8'hE3;
    endcase
  end

endmodule

// File: rtl/oled_init_sequencer.sv
// Power-up wait, init command replay, optional clear, then user byte pass-through.
// Define OLED_SEQ_CLEAR_EN to build the GDDRAM clear phase.
module oled_init_sequencer
  import oled_pkg::*;
#(
  parameter int PWRUP_CYCLES = DEF_PWRUP_CYCLES,
  parameter int INIT_LEN     = DEF_INIT_LEN
`ifdef OLED_SEQ_CLEAR_EN
  ,
  parameter int CLR_BYTES    = DEF_CLR_BYTES
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       i2c_start,
  output logic       i2c_dcn,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       usr_valid,
  input  logic       usr_dcn,
  input  logic [7:0] usr_data,
  output logic       usr_ready,
  output logic       init_done
);

  localparam int PW_W  = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  oled_state_e      state_q, state_d;
  logic [PW_W-1:0]  pwr_q, pwr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [8:0]       usr_q, usr_d;
  logic [7:0]       rom_cmd;

`ifdef OLED_SEQ_CLEAR_EN
  localparam int CLR_W = (CLR_BYTES > 1) ? $clog2(CLR_BYTES) : 1;
  logic [CLR_W-1:0] clr_q, clr_d;
`endif

  oled_init_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .idx (idx_q),
    .cmd (rom_cmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWRUP;
      pwr_q   <= '0;
      idx_q   <= '0;
      usr_q   <= '0;
`ifdef OLED_SEQ_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pwr_q   <= pwr_d;
      idx_q   <= idx_d;
      usr_q   <= usr_d;
`ifdef OLED_SEQ_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pwr_d     = pwr_q;
    idx_d     = idx_q;
    usr_d     = usr_q;
`ifdef OLED_SEQ_CLEAR_EN
    clr_d     = clr_q;
`endif
    i2c_start = 1'b0;
    i2c_dcn   = OLED_CMD;
    i2c_data  = 8'h00;
    usr_ready = 1'b0;
    init_done = 1'b0;
    unique case (state_q)
      // the engine is not reset, so a transfer may still be in flight
      ST_PWRUP: begin
        if (pwr_q == PW_W'(PWRUP_CYCLES - 1)) begin
          if (!i2c_busy) begin
            state_d = ST_CMD_ISSUE;
            idx_d   = '0;
          end
        end else begin
          pwr_d = pwr_q + 1'b1;
        end
      end
      ST_CMD_ISSUE: begin
        i2c_start = 1'b1;
        i2c_data  = rom_cmd;
        if (i2c_busy) state_d = ST_CMD_WAIT;
      end
      ST_CMD_WAIT: begin
        i2c_data = rom_cmd;
        if (!i2c_busy) begin
          if (idx_q == IDX_W'(INIT_LEN - 1)) begin
`ifdef OLED_SEQ_CLEAR_EN
            state_d = ST_CLR_ISSUE;
            clr_d   = '0;
`else
            state_d = ST_READY;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_CMD_ISSUE;
          end
        end
      end
`ifdef OLED_SEQ_CLEAR_EN
      ST_CLR_ISSUE: begin
        i2c_start = 1'b1;
        i2c_dcn   = OLED_DATA;
        if (i2c_busy) state_d = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        i2c_dcn = OLED_DATA;
        if (!i2c_busy) begin
          if (clr_q == CLR_W'(CLR_BYTES - 1)) begin
            state_d = ST_READY;
          end else begin
            clr_d   = clr_q + 1'b1;
            state_d = ST_CLR_ISSUE;
          end
        end
      end
`endif
      ST_READY: begin
        usr_ready = 1'b1;
        init_done = 1'b1;
        if (usr_valid) begin
          usr_d   = {usr_dcn, usr_data};
          state_d = ST_USR_ISSUE;
        end
      end
      ST_USR_ISSUE: begin
        init_done = 1'b1;
        i2c_start = 1'b1;
        {i2c_dcn, i2c_data} = usr_q;
        if (i2c_busy) state_d = ST_USR_WAIT;
      end
      ST_USR_WAIT: begin
        init_done = 1'b1;
        {i2c_dcn, i2c_data} = usr_q;
        if (!i2c_busy) state_d = ST_READY;
      end
      default: state_d = ST_PWRUP;
    endcase
  end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Bench for oled_init_sequencer with a behavioural I2C engine model.
// Build with OLED_SEQ_CLEAR_EN defined to cover the clear phase.
module tb_oled_init_sequencer;

  localparam int PWR = 16;
`ifdef OLED_SEQ_CLEAR_EN
  localparam int NCLR = 4;
`else
  localparam int NCLR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i2c_start, i2c_dcn, usr_ready, init_done;
  logic [7:0] i2c_data;
  logic       busy = 1'b0;
  logic       usr_valid, usr_dcn;
  logic [7:0] usr_data;

  oled_init_sequencer #(
    .PWRUP_CYCLES (PWR),
    .INIT_LEN     (31)
`ifdef OLED_SEQ_CLEAR_EN
    ,
    .CLR_BYTES    (NCLR)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2c_start (i2c_start),
    .i2c_dcn   (i2c_dcn),
    .i2c_data  (i2c_data),
    .i2c_busy  (busy),
    .usr_valid (usr_valid),
    .usr_dcn   (usr_dcn),
    .usr_data  (usr_data),
    .usr_ready (usr_ready),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // engine model: busy 1 clk after start, high for 40 clk, never reset
  int         cyc = 0;
  int         bcnt = 0;
  int         obs_wr = 0;
  logic [8:0] obs_mem [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy) begin
      if (bcnt == 1) busy <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (i2c_start) begin
      busy <= 1'b1;
      bcnt <= 40;
      obs_mem[obs_wr[7:0]] <= {i2c_dcn, i2c_data};
      obs_wr <= obs_wr + 1;
    end
  end

  typedef struct {
    logic       dcn;
    logic [7:0] data;
    logic [8:0] exp;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] rom_ref [31];
  logic [8:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;
  int         obs_rd = 0;
  int         rel_cyc, base, dbd, acc_cnt;
  int         rdy_busy_viol, sb_viol;
  bit         first_seen, restart, done_seen;
  bit         lat_pend, usr_infl, rdy_pend, prev_busy, prev_sb;
  logic [8:0] exp_next, lat_exp;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_init();
    exp_q.delete();
    for (int i = 0; i < 31; i++) exp_q.push_back({1'b0, rom_ref[i]});
    for (int i = 0; i < NCLR; i++) exp_q.push_back(9'h100);
  endtask

  task automatic mon_step();
    logic [8:0] o;
    while (obs_rd != obs_wr) begin
      o = obs_mem[obs_rd[7:0]];
      obs_rd++;
      if (!done_seen && o[8]) dbd++;
      if (exp_q.size() == 0) chk("xfer_unexpected", {23'd0, o}, 32'h1FF);
      else chk("xfer_byte", {23'd0, o}, {23'd0, exp_q.pop_front()});
    end
    if (rst_n && i2c_start && !first_seen) begin
      first_seen = 1'b1;
      chk("first_byte", {i2c_dcn, i2c_data}, 9'h0AE);
      if (!restart) chk("first_start_clk", cyc - rel_cyc, PWR);
      else chk("restart_gap_idle", (cyc - rel_cyc >= PWR) && !busy, 1);
    end
    if (init_done && !done_seen) begin
      done_seen = 1'b1;
      chk("done_busy_low", busy, 0);
      chk("done_ready", usr_ready, 1);
      chk("done_xfers", obs_wr - base, 31 + NCLR);
      chk("done_data_bytes", dbd, NCLR);
    end
    if (lat_pend) begin
      chk("usr_start_lat", {i2c_start, i2c_dcn, i2c_data}, {1'b1, lat_exp});
      lat_pend = 1'b0;
    end
    if (rdy_pend) begin
      chk("ready_reassert", usr_ready, 1);
      rdy_pend = 1'b0;
    end
    if (usr_infl && prev_busy && !busy) begin
      chk("ready_low_at_fall", usr_ready, 0);
      rdy_pend = 1'b1;
      usr_infl = 1'b0;
    end
    if (usr_valid && usr_ready) begin
      exp_q.push_back(exp_next);
      lat_exp  = exp_next;
      lat_pend = 1'b1;
      usr_infl = 1'b1;
      acc_cnt++;
    end
    if (usr_ready && busy) rdy_busy_viol++;
    if (i2c_start && busy && prev_sb) sb_viol++;
    prev_sb   = i2c_start && busy;
    prev_busy = busy;
  endtask

  initial begin
    int n;
    rom_ref = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};
    tbl[0] = '{1'b1, 8'hA5, 9'h1A5};
    tbl[1] = '{1'b0, 8'hAE, 9'h0AE};
    tbl[2] = '{1'b1, 8'h00, 9'h100};
    tbl[3] = '{1'b1, 8'hFF, 9'h1FF};
    tbl[4] = '{1'b0, 8'h81, 9'h081};
    tbl[5] = '{1'b1, 8'h3C, 9'h13C};
    rst_n = 1'b0;
    usr_valid = 1'b1;
    usr_dcn = 1'b1;
    usr_data = 8'h5A;
    exp_next = 9'h15A;
    {dbd, acc_cnt, rdy_busy_viol, sb_viol, rel_cyc, base} = '0;
    {first_seen, restart, done_seen} = '0;
    {lat_pend, usr_infl, rdy_pend, prev_busy, prev_sb} = '0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", i2c_start, 0);
    chk("rst_dcn_data", {i2c_dcn, i2c_data}, 0);
    chk("rst_ready", usr_ready, 0);
    chk("rst_done", init_done, 0);
    load_init();
    rst_n = 1'b1;
    rel_cyc = cyc;
    base = obs_wr;

    n = 0;
    while (!((obs_wr - base) >= 11 && busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_idx10", n < 3000, 1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {i2c_start, i2c_dcn, i2c_data, usr_ready, init_done}, 0);
    load_init();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    base = obs_wr;
    dbd = 0;
    first_seen = 1'b0;
    restart = 1'b1;

    n = 0;
    while (!init_done && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_done_seen", init_done, 1);

    n = 0;
    while (acc_cnt < 2 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held_valid_accepts", acc_cnt >= 2, 1);
    usr_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!usr_ready && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("vec_ready", usr_ready, 1);
      exp_next = tbl[i].exp;
      usr_dcn = tbl[i].dcn;
      usr_data = tbl[i].data;
      usr_valid = 1'b1;
      @(posedge clk);
      #1;
      usr_valid = 1'b0;
    end

    n = 0;
    while ((exp_q.size() != 0 || busy || !usr_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("accept_count", acc_cnt, 8);
    chk("ready_while_busy", rdy_busy_viol, 0);
    chk("start_held_in_wait", sb_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
